hmr_recovery_seq: RTL and testbench
===================================

HMR_RECOVERY_SEQ -- requirements
Module: hmr_recovery_seq

Interface
REQ-001 SHALL have parameter NumIntRegs, default 32, number of integer RF entries (x0 never restored).
REQ-002 SHALL have parameter SetbackCycles, default 4, length of the core setback pulse in cycles (>=1).
REQ-003 SHALL have parameter HaltTimeout, default 255, maximum cycles waited in HALT or RELEASE (>=1).
REQ-004 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port recovery_request_i  in  1  recovery request from the DMR control unit; level or pulse.
REQ-007 SHALL have port recovery_finished_o  out  1  one-cycle pulse when recovery completes.
REQ-008 SHALL have port recovery_failed_o  out  1  one-cycle pulse on halt/release timeout.
REQ-009 SHALL have port busy_o  out  1  high whenever the state is not IDLE.
REQ-010 SHALL have port halt_req_o  out  1  debug-halt request to both cores of the pair.
REQ-011 SHALL have port halted_i  in  2  per-core halted status, bit i for core i.
REQ-012 SHALL have port instr_lock_o  out  1  blocks instruction fetch for both cores.
REQ-013 SHALL have port core_setback_o  out  1  synchronous core state setback.
REQ-014 SHALL have port pc_recover_o  out  1  load checkpointed PC into both cores.
REQ-015 SHALL have port rf_restore_en_o  out  1  recovery RF read and core RF write enable.
REQ-016 SHALL have port rf_restore_addr_o  out  $clog2(NumIntRegs)  RF index being restored.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, HALT, SETBACK, RESTORE_PC, RESTORE_RF, RELEASE, FINISH, FAIL; all outputs decoded from registered state/counters only.
REQ-018 IDLE: all outputs 0; recovery_request_i=1 at a clock edge -> HALT next cycle.
REQ-019 recovery_request_i SHALL be ignored in every state except IDLE (no queuing).
REQ-020 HALT: halt_req_o=1, instr_lock_o=1; halted_i==2'b11 -> SETBACK next cycle.
REQ-021 HALT: timeout counter clears on entry, increments each cycle; if halted_i!=2'b11 in the HaltTimeout-th HALT cycle -> FAIL; halted_i==2'b11 in that cycle wins over timeout.
REQ-022 SETBACK: halt_req_o=1, instr_lock_o=1, core_setback_o=1 for exactly SetbackCycles cycles -> RESTORE_PC.
REQ-023 RESTORE_PC: halt_req_o=1, instr_lock_o=1, pc_recover_o=1 for exactly one cycle -> RESTORE_RF.
REQ-024 RESTORE_RF: halt_req_o=1, instr_lock_o=1, rf_restore_en_o=1, rf_restore_addr_o steps 1,2,...,NumIntRegs-1, one per cycle, no gaps; after NumIntRegs-1 -> RELEASE.
REQ-025 rf_restore_addr_o SHALL be 0 outside RESTORE_RF; address counter SHALL never wrap to 0 within RESTORE_RF.
REQ-026 RELEASE: halt_req_o=0, instr_lock_o=1; halted_i==2'b00 -> FINISH; same timeout rule as REQ-021 -> FAIL.
REQ-027 FINISH: recovery_finished_o=1, instr_lock_o=0, one cycle -> IDLE.
REQ-028 FAIL: recovery_failed_o=1, halt_req_o=0, instr_lock_o=0, one cycle -> IDLE.
REQ-029 recovery_finished_o and recovery_failed_o SHALL never be high together.
REQ-030 Nominal latency, halted_i=2'b11 on first HALT cycle, defaults: request edge cycle 0, HALT cycle 1, SETBACK 2-5, RESTORE_PC 6, RESTORE_RF 7-37, RELEASE 38, FINISH 39.
REQ-031 halted_i dropping to non-2'b11 during SETBACK/RESTORE_PC/RESTORE_RF SHALL NOT alter the sequence.

Reset
REQ-032 rst_ni low SHALL asynchronously force IDLE, clear timeout and address/setback counters, and drive all outputs 0.
REQ-033 Reset mid-recovery SHALL abort without a finished or failed pulse; first post-reset cycle is IDLE.

Verification
REQ-034 Request pulse, halted_i=11 from cycle 1 -> exact REQ-030 timeline; rf_restore_addr_o 1..31; one finished pulse at cycle 39.
REQ-035 Request, halted_i stays 2'b01 -> FAIL at cycle 256, recovery_failed_o one cycle, then IDLE with all outputs 0.
REQ-036 halted_i becomes 11 exactly on 255th HALT cycle -> SETBACK, no failure.
REQ-037 Request held high through whole sequence and during FINISH -> exactly one recovery run; new run only if request still high in IDLE.
REQ-038 rst_ni low at cycle 20 (RESTORE_RF) -> outputs 0 immediately, no finished pulse, idle afterwards.
REQ-039 RELEASE with halted_i held 11 for 300 cycles -> FAIL after 255 RELEASE cycles, halt_req_o 0 throughout RELEASE.

Source files
------------

// File: rtl/hmr_recovery_seq.sv
// Recovery sequencer for a hybrid-modular-redundant core pair: halts both cores,
// sets them back, reloads PC and integer RF from the checkpoint, then releases them.
module hmr_recovery_seq #(
  parameter int unsigned NumIntRegs    = 32,
  parameter int unsigned SetbackCycles = 4,
  parameter int unsigned HaltTimeout   = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          recovery_request_i,
  output logic                          recovery_finished_o,
  output logic                          recovery_failed_o,
  output logic                          busy_o,
  output logic                          halt_req_o,
  input  logic [1:0]                    halted_i,
  output logic                          instr_lock_o,
  output logic                          core_setback_o,
  output logic                          pc_recover_o,
  output logic                          rf_restore_en_o,
  output logic [$clog2(NumIntRegs)-1:0] rf_restore_addr_o
);

  localparam int unsigned AddrW = $clog2(NumIntRegs);
  localparam int unsigned TmoW  = $clog2(HaltTimeout + 1);
  localparam int unsigned SbW   = $clog2(SetbackCycles + 1);

  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(HaltTimeout - 1);
  localparam logic [SbW-1:0]   SbLast   = SbW'(SetbackCycles - 1);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(NumIntRegs - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_SETBACK,
    S_RESTORE_PC,
    S_RESTORE_RF,
    S_RELEASE,
    S_FINISH,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [SbW-1:0]   sb_q, sb_d;
  logic [AddrW-1:0] addr_q, addr_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    sb_d    = sb_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (recovery_request_i) begin
          state_d = S_HALT;
          tmo_d   = '0;
        end
      end
      S_HALT: begin
        // Both cores halting in the last allowed cycle still counts as success.
        if (halted_i == 2'b11) begin
          state_d = S_SETBACK;
          sb_d    = '0;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = S_FAIL;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      S_SETBACK: begin
        if (sb_q == SbLast) begin
          state_d = S_RESTORE_PC;
          sb_d    = '0;
        end else begin
          sb_d = sb_q + SbW'(1);
        end
      end
      S_RESTORE_PC: begin
        state_d = S_RESTORE_RF;
        addr_d  = AddrW'(1);
      end
      S_RESTORE_RF: begin
        // x0 is hard-wired, so the walk runs 1..NumIntRegs-1 and never wraps.
        if (addr_q == AddrLast) begin
          state_d = S_RELEASE;
          addr_d  = '0;
          tmo_d   = '0;
        end else begin
          addr_d = addr_q + AddrW'(1);
        end
      end
      S_RELEASE: begin
        if (halted_i == 2'b00) begin
          state_d = S_FINISH;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = S_FAIL;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      sb_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      sb_q    <= sb_d;
      addr_q  <= addr_d;
    end
  end

  // Moore decode: outputs depend only on registered state and counters.
  always_comb begin
    recovery_finished_o = 1'b0;
    recovery_failed_o   = 1'b0;
    halt_req_o          = 1'b0;
    instr_lock_o        = 1'b0;
    core_setback_o      = 1'b0;
    pc_recover_o        = 1'b0;
    rf_restore_en_o     = 1'b0;
    rf_restore_addr_o   = '0;
    unique case (state_q)
      S_HALT: begin
        halt_req_o   = 1'b1;
        instr_lock_o = 1'b1;
      end
      S_SETBACK: begin
        halt_req_o     = 1'b1;
        instr_lock_o   = 1'b1;
        core_setback_o = 1'b1;
      end
      S_RESTORE_PC: begin
        halt_req_o   = 1'b1;
        instr_lock_o = 1'b1;
        pc_recover_o = 1'b1;
      end
      S_RESTORE_RF: begin
        halt_req_o        = 1'b1;
        instr_lock_o      = 1'b1;
        rf_restore_en_o   = 1'b1;
        rf_restore_addr_o = addr_q;
      end
      S_RELEASE: instr_lock_o        = 1'b1;
      S_FINISH:  recovery_finished_o = 1'b1;
      S_FAIL:    recovery_failed_o   = 1'b1;
      default: ;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_hmr_recovery_seq.sv
// Cycle-accurate vector bench for hmr_recovery_seq: expected outputs come from
// the phase timeline of each recovery scenario, queued and compared per cycle.
module tb_hmr_recovery_seq;

  localparam int HT    = 255;
  localparam int NREGS = 32;
  localparam int SBC   = 4;

  typedef struct packed {
    logic       fin;
    logic       fail;
    logic       busy;
    logic       hreq;
    logic       lock;
    logic       sb;
    logic       pc;
    logic       rfen;
    logic [4:0] addr;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic       req;
    logic [1:0] halted;
    out_t       exp;
  } vec_t;

  typedef enum {P_IDLE, P_HALT, P_SB, P_PC, P_RF, P_REL, P_FIN, P_FAIL} ph_e;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] halted;
  logic       fin, fail, busy, hreq, lock, sb, pc, rfen;
  logic [4:0] addr;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  hmr_recovery_seq dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .recovery_request_i  (req),
    .recovery_finished_o (fin),
    .recovery_failed_o   (fail),
    .busy_o              (busy),
    .halt_req_o          (hreq),
    .halted_i            (halted),
    .instr_lock_o        (lock),
    .core_setback_o      (sb),
    .pc_recover_o        (pc),
    .rf_restore_en_o     (rfen),
    .rf_restore_addr_o   (addr)
  );

  always #5 clk = ~clk;

  function automatic out_t exp_of(ph_e p, int a);
    out_t e = '0;
    case (p)
      P_HALT: begin e.busy = 1; e.hreq = 1; e.lock = 1; end
      P_SB:   begin e.busy = 1; e.hreq = 1; e.lock = 1; e.sb = 1; end
      P_PC:   begin e.busy = 1; e.hreq = 1; e.lock = 1; e.pc = 1; end
      P_RF:   begin e.busy = 1; e.hreq = 1; e.lock = 1; e.rfen = 1; e.addr = 5'(a); end
      P_REL:  begin e.busy = 1; e.lock = 1; end
      P_FIN:  begin e.busy = 1; e.fin = 1; end
      P_FAIL: begin e.busy = 1; e.fail = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic void add(logic r, logic q, logic [1:0] h, ph_e p, int a);
    vec_t v;
    v.rst_n  = r;
    v.req    = q;
    v.halted = h;
    v.exp    = exp_of(p, a);
    tbl.push_back(v);
  endfunction

  function automatic void add_idle(int n, logic q, logic [1:0] h);
    for (int i = 0; i < n; i++) add(1'b1, q, h, P_IDLE, 0);
  endfunction

  // One recovery run starting with the request cycle (cycle 0, IDLE).
  // h/r: HALT/RELEASE cycles before the cores respond; hfail/rfail: never respond.
  function automatic void gen_run(int h, int r, bit hfail, bit rfail, bit hold, bit glitch);
    logic [1:0] mid;
    mid = glitch ? 2'b10 : 2'b11;
    add(1'b1, 1'b1, 2'b00, P_IDLE, 0);
    if (hfail) begin
      for (int i = 0; i < HT; i++) add(1'b1, hold, 2'b01, P_HALT, 0);
      add(1'b1, hold, 2'b01, P_FAIL, 0);
      return;
    end
    for (int i = 0; i < h; i++) add(1'b1, hold, (i == h - 1) ? 2'b11 : 2'b01, P_HALT, 0);
    for (int i = 0; i < SBC; i++) add(1'b1, hold, mid, P_SB, 0);
    add(1'b1, hold, mid, P_PC, 0);
    for (int a = 1; a < NREGS; a++) add(1'b1, hold, mid, P_RF, a);
    if (rfail) begin
      for (int i = 0; i < HT; i++) add(1'b1, hold, 2'b11, P_REL, 0);
      add(1'b1, hold, 2'b11, P_FAIL, 0);
      return;
    end
    for (int i = 0; i < r; i++) add(1'b1, hold, (i == r - 1) ? 2'b00 : 2'b11, P_REL, 0);
    add(1'b1, hold, 2'b00, P_FIN, 0);
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got fin=%b fail=%b busy=%b hreq=%b lock=%b sb=%b pc=%b rfen=%b addr=%0d, expected fin=%b fail=%b busy=%b hreq=%b lock=%b sb=%b pc=%b rfen=%b addr=%0d",
               name, got.fin, got.fail, got.busy, got.hreq, got.lock, got.sb, got.pc, got.rfen, got.addr,
               exp.fin, exp.fail, exp.busy, exp.hreq, exp.lock, exp.sb, exp.pc, exp.rfen, exp.addr);
    end
  endtask

  // Drive one cycle's inputs mid-cycle, then sample the outputs shortly after.
  task automatic apply_vec(input vec_t v, input string name);
    out_t got;
    @(negedge clk);
    rst_n  = v.rst_n;
    req    = v.req;
    halted = v.halted;
    exp_q.push_back(v.exp);
    #1;
    got = '{fin, fail, busy, hreq, lock, sb, pc, rfen, addr};
    check(name, got, exp_q.pop_front());
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("%s_c%0d", tag, i));
    tbl.delete();
  endtask

  initial begin
    rst_n  = 1'b1;
    req    = 1'b0;
    halted = 2'b00;
    #2 rst_n = 1'b0;

    // Reset state, including a request while held in reset.
    add(1'b0, 1'b0, 2'b00, P_IDLE, 0);
    add(1'b0, 1'b1, 2'b11, P_IDLE, 0);
    add_idle(2, 1'b0, 2'b00);
    run_table("reset");

    // Nominal timeline: HALT 1, SETBACK 2-5, PC 6, RF 7-37, RELEASE 38, FINISH 39.
    gen_run(1, 1, 0, 0, 0, 0);
    add_idle(2, 1'b0, 2'b00);
    run_table("nominal");

    // halted_i glitching during SETBACK/PC/RF, slower halt and release.
    gen_run(3, 2, 0, 0, 0, 1);
    add_idle(1, 1'b0, 2'b00);
    run_table("glitch");

    // Cores never halt: FAIL at cycle 256, then idle.
    gen_run(0, 0, 1, 0, 0, 0);
    add_idle(2, 1'b0, 2'b01);
    run_table("halt_tmo");

    // Cores halt exactly in the last HALT cycle: success wins over timeout.
    gen_run(HT, 1, 0, 0, 0, 0);
    add_idle(1, 1'b0, 2'b00);
    run_table("halt_edge");

    // Request held high throughout: no re-trigger from FINISH, new run only from IDLE.
    gen_run(1, 1, 0, 0, 1, 0);
    gen_run(1, 1, 0, 0, 1, 0);
    add_idle(3, 1'b0, 2'b00);
    run_table("hold");

    // Cores stay halted in RELEASE: FAIL after 255 RELEASE cycles.
    gen_run(1, 0, 0, 1, 0, 0);
    add_idle(3, 1'b0, 2'b11);
    run_table("rel_tmo");

    // Reset asserted in cycle 20 (RESTORE_RF, addr 14): outputs clear at once.
    add(1'b1, 1'b1, 2'b00, P_IDLE, 0);
    add(1'b1, 1'b0, 2'b11, P_HALT, 0);
    for (int i = 0; i < SBC; i++) add(1'b1, 1'b0, 2'b11, P_SB, 0);
    add(1'b1, 1'b0, 2'b11, P_PC, 0);
    for (int a = 1; a <= 13; a++) add(1'b1, 1'b0, 2'b11, P_RF, a);
    add(1'b0, 1'b0, 2'b11, P_IDLE, 0);
    add(1'b0, 1'b0, 2'b00, P_IDLE, 0);
    add_idle(3, 1'b0, 2'b00);
    run_table("midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
